// File: rtl/gray_sync_decoder_if.sv
// Gray-count decoder bundle: source drives g_in,
// decoder returns binary value, step pulses and lock/error status.
interface gray_sync_decoder_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       g_in;
  logic [3:0]       b_out;
  logic             valid;
  logic             step_up;
  logic             step_dn;
  logic             jump_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output g_in,
    input  b_out, valid, step_up, step_dn,
    input  jump_err, locked, err_cnt
  );

  modport slave (
    input  g_in,
    output b_out, valid, step_up, step_dn,
    output jump_err, locked, err_cnt
  );
endinterface

// File: rtl/gray_sync_decoder.sv
// Synchronises an async 4-bit Gray count, decodes it to binary and
// classifies each change as +1, -1 or an illegal jump with lock tracking.
module gray_sync_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int ERR_W       = 8
) (
  input logic clk,
  input logic rst_n,
  gray_sync_decoder_if.slave bus
);
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [2:0] INIT_END = SYNC_STAGES[2:0];
  localparam logic [3:0] LOCK_END = LOCK_COUNT[3:0];

  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       g_sync;
  logic [3:0]       g_prev;
  logic [3:0]       b_new;
  logic [3:0]       b_q;
  logic [1:0]       state;
  logic [2:0]       init_cnt;
  logic [3:0]       lock_cnt;
  logic [3:0]       lock_nxt;
  logic [ERR_W-1:0] err_q;
  logic             valid_q;
  logic             up_q;
  logic             dn_q;
  logic             err_p;
  logic             lock_q;
  logic             changed;
  logic             is_up;
  logic             is_dn;

  assign g_sync = sync_q[SYNC_STAGES-1];

  assign b_new[3] = g_sync[3];
  assign b_new[2] = b_new[3] ^ g_sync[2];
  assign b_new[1] = b_new[2] ^ g_sync[1];
  assign b_new[0] = b_new[1] ^ g_sync[0];

  assign changed  = g_sync != g_prev;
  assign is_up    = b_new == 4'(b_q + 4'd1);
  assign is_dn    = b_new == 4'(b_q - 4'd1);
  assign lock_nxt = (lock_cnt == LOCK_END) ? lock_cnt
                                           : lock_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.g_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
      lock_cnt <= '0;
      g_prev   <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_p    <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      err_p <= 1'b0;
      if (state == S_INIT) begin
        if (init_cnt == INIT_END) begin
          g_prev  <= g_sync;
          b_q     <= b_new;
          valid_q <= 1'b1;
          state   <= S_ACQ;
        end else begin
          init_cnt <= init_cnt + 3'd1;
        end
      end else if (changed) begin
        g_prev <= g_sync;
        b_q    <= b_new;
        unique case (1'b1)
          is_up, is_dn: begin
            up_q     <= is_up;
            dn_q     <= is_dn;
            lock_cnt <= lock_nxt;
            if (lock_nxt == LOCK_END) begin
              lock_q <= 1'b1;
              state  <= S_LOCK;
            end
          end
          default: begin
            // error drops lock on the same edge the pulse rises
            err_p    <= 1'b1;
            lock_cnt <= '0;
            lock_q   <= 1'b0;
            state    <= S_ACQ;
            if (err_q != '1) err_q <= err_q + 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.b_out    = b_q;
  assign bus.valid    = valid_q;
  assign bus.step_up  = up_q;
  assign bus.step_dn  = dn_q;
  assign bus.jump_err = err_p;
  assign bus.locked   = lock_q;
  assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (SYNC_STAGES=2, LOCK_COUNT=4,
// ERR_W=2 so saturation is reachable in a few jumps).
module tb_gray_sync_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  int n_up, n_dn, n_err, n_multi;
  int rise_up, n_fall;
  logic prev_lock;
  logic err_lock;
  logic [3:0] err_b;
  logic [1:0] errs [8];

  gray_sync_decoder_if #(.ERR_W(2)) bus ();

  gray_sync_decoder #(
    .SYNC_STAGES(2),
    .LOCK_COUNT(4),
    .ERR_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tally();
    n_up = 0; n_dn = 0; n_err = 0; n_multi = 0;
    rise_up = -1; n_fall = 0;
    prev_lock = bus.locked;
    err_lock = 1'bx; err_b = 'x;
  endtask

  task automatic hold(input logic [3:0] g, input int n);
    bus.g_in = g;
    for (int i = 0; i < n; i++) begin
      tick();
      if (int'(bus.step_up) + int'(bus.step_dn)
          + int'(bus.jump_err) > 1) n_multi++;
      if (bus.step_up) n_up++;
      if (bus.step_dn) n_dn++;
      if (bus.jump_err) begin
        if (n_err < 8) errs[n_err] = bus.err_cnt;
        err_lock = bus.locked;
        err_b = bus.b_out;
        n_err++;
      end
      if (bus.locked && !prev_lock && rise_up < 0) rise_up = n_up;
      if (!bus.locked && prev_lock) n_fall++;
      prev_lock = bus.locked;
    end
  endtask

  task automatic apply_reset(input logic [3:0] g);
    bus.g_in = g;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    bus.g_in = 4'b0110;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({bus.valid, bus.b_out, bus.step_up, bus.step_dn,
         bus.jump_err, bus.locked, bus.err_cnt} !== 11'd0) begin
      bad++;
      $display("FAIL reset_hold got v=%b b=%0d l=%b e=%0d want all 0",
               bus.valid, bus.b_out, bus.locked, bus.err_cnt);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++;
      if (bus.valid !== 1'b0 || bus.b_out !== 4'd0) begin
        bad++;
        $display("FAIL init_edge%0d got v=%b b=%0d want v=0 b=0",
                 k, bus.valid, bus.b_out);
      end
    end
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.b_out !== 4'd4) begin
      bad++;
      $display("FAIL init_load got v=%b b=%0d want v=1 b=4",
               bus.valid, bus.b_out);
    end
    total++;
    if ({bus.step_up, bus.step_dn, bus.jump_err, bus.locked} !== 4'b0) begin
      bad++;
      $display("FAIL init_pulses got %b want 0000",
               {bus.step_up, bus.step_dn, bus.jump_err, bus.locked});
    end
  endtask

  task automatic test_up_wrap();
    apply_reset(4'b1110);
    total++;
    if (bus.b_out !== 4'd11 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL up_start got b=%0d v=%b want b=11 v=1",
               bus.b_out, bus.valid);
    end
    clear_tally();
    hold(4'b1010, 4); hold(4'b1011, 4); hold(4'b1001, 4);
    hold(4'b1000, 4); hold(4'b0000, 4);
    total++;
    if (n_up != 5 || n_dn != 0 || n_err != 0 || n_multi != 0) begin
      bad++;
      $display("FAIL up_pulses got up=%0d dn=%0d err=%0d multi=%0d want 5/0/0/0",
               n_up, n_dn, n_err, n_multi);
    end
    total++;
    if (bus.b_out !== 4'd0) begin
      bad++;
      $display("FAIL up_wrap_b got %0d want 0", bus.b_out);
    end
    total++;
    if (rise_up != 4 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL up_lock got rise_at=%0d locked=%b want 4/1",
               rise_up, bus.locked);
    end
    total++;
    if (bus.err_cnt !== 2'd0) begin
      bad++;
      $display("FAIL up_errcnt got %0d want 0", bus.err_cnt);
    end
  endtask

  task automatic test_down();
    clear_tally();
    hold(4'b1000, 4); hold(4'b1001, 4);
    total++;
    if (n_dn != 2 || n_up != 0 || n_err != 0) begin
      bad++;
      $display("FAIL dn_pulses got dn=%0d up=%0d err=%0d want 2/0/0",
               n_dn, n_up, n_err);
    end
    total++;
    if (bus.b_out !== 4'd14 || bus.locked !== 1'b1 || n_fall != 0) begin
      bad++;
      $display("FAIL dn_state got b=%0d l=%b falls=%0d want 14/1/0",
               bus.b_out, bus.locked, n_fall);
    end
  endtask

  task automatic test_jump();
    hold(4'b1000, 4); hold(4'b0000, 4); hold(4'b0001, 4);
    hold(4'b0011, 4); hold(4'b0010, 4); hold(4'b0110, 4);
    hold(4'b0111, 4);
    total++;
    if (bus.b_out !== 4'd5 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL jump_pre got b=%0d l=%b want 5/1",
               bus.b_out, bus.locked);
    end
    clear_tally();
    hold(4'b1100, 4);
    total++;
    if (n_err != 1 || n_up != 0 || n_dn != 0) begin
      bad++;
      $display("FAIL jump_pulse got err=%0d up=%0d dn=%0d want 1/0/0",
               n_err, n_up, n_dn);
    end
    total++;
    if (err_b !== 4'd8 || err_lock !== 1'b0 || errs[0] !== 2'd1) begin
      bad++;
      $display("FAIL jump_edge got b=%0d l=%b ec=%0d want 8/0/1",
               err_b, err_lock, errs[0]);
    end
    clear_tally();
    hold(4'b1101, 4); hold(4'b1111, 4); hold(4'b1110, 4);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL relock_early got locked=%b want 0", bus.locked);
    end
    hold(4'b1010, 4);
    total++;
    if (n_up != 4 || rise_up != 4 || bus.locked !== 1'b1 ||
        bus.b_out !== 4'd12) begin
      bad++;
      $display("FAIL relock got up=%0d rise=%0d l=%b b=%0d want 4/4/1/12",
               n_up, rise_up, bus.locked, bus.b_out);
    end
  endtask

  task automatic test_saturation();
    apply_reset(4'b0000);
    clear_tally();
    hold(4'b1100, 4); hold(4'b0000, 4); hold(4'b1100, 4);
    hold(4'b0000, 4); hold(4'b1100, 4);
    total++;
    if (n_err != 5 || n_up != 0 || n_dn != 0) begin
      bad++;
      $display("FAIL sat_pulses got err=%0d up=%0d dn=%0d want 5/0/0",
               n_err, n_up, n_dn);
    end
    total++;
    if (errs[0] !== 2'd1 || errs[1] !== 2'd2 || errs[2] !== 2'd3 ||
        errs[3] !== 2'd3 || errs[4] !== 2'd3) begin
      bad++;
      $display("FAIL sat_seq got %0d,%0d,%0d,%0d,%0d want 1,2,3,3,3",
               errs[0], errs[1], errs[2], errs[3], errs[4]);
    end
  endtask

  task automatic test_reset_mid();
    clear_tally();
    hold(4'b1101, 4); hold(4'b1111, 4); hold(4'b1110, 4);
    hold(4'b1010, 4);
    total++;
    if (bus.locked !== 1'b1 || bus.err_cnt !== 2'd3) begin
      bad++;
      $display("FAIL mid_pre got l=%b ec=%0d want 1/3",
               bus.locked, bus.err_cnt);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.valid, bus.b_out, bus.step_up, bus.step_dn,
         bus.jump_err, bus.locked, bus.err_cnt} !== 11'd0) begin
      bad++;
      $display("FAIL mid_async_clear got v=%b b=%0d l=%b ec=%0d want all 0",
               bus.valid, bus.b_out, bus.locked, bus.err_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if (bus.valid !== 1'b0 || bus.b_out !== 4'd0) begin
      bad++;
      $display("FAIL mid_init got v=%b b=%0d want 0/0",
               bus.valid, bus.b_out);
    end
    clear_tally();
    hold(4'b1010, 4);
    total++;
    if (bus.valid !== 1'b1 || bus.b_out !== 4'd12 ||
        n_up + n_dn + n_err != 0 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL mid_reinit got v=%b b=%0d pulses=%0d l=%b want 1/12/0/0",
               bus.valid, bus.b_out, n_up + n_dn + n_err, bus.locked);
    end
  endtask

  initial begin
    bus.g_in = 4'b0000;
    test_reset();
    test_up_wrap();
    test_down();
    test_jump();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
- Downstream consumer of the 4-bit binary-to-Gray stage. It receives a Gray-coded count that may come from another clock domain.
- Synchronises the count into the local clock, converts it back to binary, and classifies each change as +1, -1 or illegal jump.
- Tracks lock status and counts jump errors, so position/count logic can trust the binary value.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on g_in (legal 2..4)
- LOCK_COUNT, 4, consecutive legal steps needed to assert locked (legal 1..15)
- ERR_W, 8, width of the saturating jump-error counter

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- g_in  input  4  Gray count {g3,g2,g1,g0}; asynchronous to clk, at most one bit changes per source update
- b_out  output  4  decoded binary count, registered
- valid  output  1  b_out holds a decoded sample
- step_up  output  1  one-cycle pulse: new value = previous + 1 mod 16
- step_dn  output  1  one-cycle pulse: new value = previous - 1 mod 16
- jump_err  output  1  one-cycle pulse: value changed by anything other than +/-1
- locked  output  1  LOCK_COUNT consecutive legal steps seen since last error or reset
- err_cnt  output  ERR_W  saturating count of jump_err pulses

Behaviour:
- Reset (async on rst_n low, regardless of clk):
  - Clears the sync chain, g_prev, b_out, valid, step_up, step_dn, jump_err, locked, err_cnt, the lock counter and the init counter.
  - FSM goes to INIT.
  - Reset mid-operation discards all history.
- Synchroniser: SYNC_STAGES flops clocked by clk; g_sync is the last stage. No logic sits between the stages.
- Decode, combinational from g_sync:
  - b[3] = g[3]
  - b[2] = b[3]^g[2]
  - b[1] = b[2]^g[1]
  - b[0] = b[1]^g[0]
  - Result is b_new.
- FSM states:
  - INIT:
    - Counts SYNC_STAGES clocks after reset release.
    - On the following clock it loads g_prev=g_sync and b_out=b_new, sets valid=1, and moves to ACQ.
    - Produces no step or error pulses.
  - ACQ:
    - Each clock, compares b_new with b_out. Equal: hold, no pulse, lock counter unchanged.
    - b_new == b_out+1 mod 16: step_up=1, lock counter +1.
    - b_new == b_out-1 mod 16: step_dn=1, lock counter +1.
    - Any other change: jump_err=1, err_cnt+1 (saturating at all-ones), lock counter cleared to 0.
    - Whenever the value changes, b_out and g_prev load the new value, including on an error.
    - When the lock counter reaches LOCK_COUNT: locked=1, go to LOCK.
  - LOCK:
    - Same classification as ACQ.
    - Legal steps and holds keep LOCK.
    - jump_err: locked=0 on the same edge the pulse asserts, lock counter cleared, go to ACQ.
- Pulses are registered, last exactly one clock, and are mutually exclusive.
- Wrap: 15->0 is step_up; 0->15 is step_dn.
- Latency: a g_in change settled before clk edge k appears on b_out and the pulses after edge k+SYNC_STAGES. That is SYNC_STAGES+1 edges including the capture edge.
- valid stays 1 until the next reset.
- The lock counter saturates at LOCK_COUNT.
- err_cnt never wraps.

Test Plan:
- Reset and init, SYNC_STAGES=2, g_in=4'b0110 held:
  - rst_n low, then high.
  - Required: all outputs 0 for 2 clocks.
  - On the 3rd edge: valid=1, b_out=4, no pulses, locked=0.
- Up count with wrap:
  - Drive Gray sequence 12,13,14,15,0 (1010,1011,1001,1000,0000), each held 4 clocks.
  - Required: 5 step_up pulses; b_out ends at 0.
  - locked rises on the edge of the 4th step_up; err_cnt=0.
- Down count:
  - From locked at b_out=0, drive Gray 1000 (15) then 1001 (14).
  - Required: two step_dn pulses; b_out=14; locked stays 1.
- Illegal jump:
  - From locked at b_out=5 (0111), drive 1100 (8).
  - Required: jump_err one clock, b_out=8, locked=0 the same edge, err_cnt=1.
  - Required afterwards: 4 further legal steps re-assert locked.
- Saturation:
  - With ERR_W=2, force 5 illegal jumps.
  - Required: err_cnt = 1,2,3,3,3; jump_err pulses all 5 times.
- Reset mid-stream:
  - While locked with err_cnt=3, pulse rst_n low asynchronously between clock edges.
  - Required: immediate clear of every output.
  - Required: INIT sequence repeats; the first value after INIT produces no pulse.
